reg_file: RTL and testbench

Architectural register file for the single-cycle MIPS datapath, sitting directly upstream of the ALU: its two read ports supply ALU operands A and B (rs, rt), and its write port commits the write-back result (ALU result or memory data) at the end of each instruction cycle. It holds 2**ADDR_WIDTH general-purpose registers, with register 0 hardwired to zero. Reads are combinational and writes are synchronous, so an instruction completes in one clock.

---
 rtl/reg_file.sv | 75 +++++++
 tb/tb_reg_file.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous write port, r0 = 0.
// Optional write-first bypass on the read ports is enabled by defining REGFILE_BYPASS_EN.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    output logic [DATA_WIDTH-1:0] rd_data1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data2,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [Depth];
    logic                  wr_fire;
    logic                  byp1;
    logic                  byp2;
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    // r0 is never written, so it keeps its reset value of zero.
    assign wr_fire = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (rd_addr1 != '0) begin
            stored1 = regs_q[rd_addr1];
        end
        if (rd_addr2 != '0) begin
            stored2 = regs_q[rd_addr2];
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Gated by rst_n so a write presented during reset is never forwarded.
    assign byp1 = rst_n && wr_fire && (rd_addr1 == wr_addr);
    assign byp2 = rst_n && wr_fire && (rd_addr2 == wr_addr);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        dbg_data = '0;
        if (rst_n) begin
            rd_data1 = byp1 ? wr_data : stored1;
            rd_data2 = byp2 ? wr_data : stored2;
            if (dbg_addr != '0) begin
                dbg_data = regs_q[dbg_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected values, a monitor pops and compares
// them whenever a sample strobe fires. Expectations for read-during-write follow REGFILE_BYPASS_EN.
module tb_reg_file;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] rd_addr1;
    logic [DW-1:0] rd_data1;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] rd_data2;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    reg_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr1(rd_addr1),
        .rd_data1(rd_data1),
        .rd_addr2(rd_addr2),
        .rd_data2(rd_data2),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // port: 0 = rd_data1, 1 = rd_data2, 2 = dbg_data
    typedef struct {
        int            port;
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    initial begin : monitor
        exp_t          e;
        logic [DW-1:0] act;
        forever begin
            @(sample_ev);
            while (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                case (e.port)
                    0:       act = rd_data1;
                    1:       act = rd_data2;
                    default: act = dbg_data;
                endcase
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h, expected %h at %0t", e.name, act, e.exp, $time);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic expect_val(input int port, input logic [DW-1:0] exp, input string name);
        exp_t e;
        e.port = port;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endtask

    // Let combinational reads settle, then hand queued expectations to the monitor.
    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] ad);
        rd_addr1 = a1;
        rd_addr2 = a2;
        dbg_addr = ad;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin : stimulus
        logic [DW-1:0] rdw_exp;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        set_rd(5'd0, 5'd0, 5'd0);

        // Reset held for two cycles, then sweep every address.
        tick();
        tick();
        rst_n = 1'b1;
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a), 5'(a));
            expect_val(0, 32'h0, "reset_sweep_rd1");
            expect_val(1, 32'h0, "reset_sweep_rd2");
            expect_val(2, 32'h0, "reset_sweep_dbg");
            sample();
        end

        // Basic write/read on both ports.
        write(5'd5, 32'hDEAD_BEEF);
        write(5'd31, 32'h0000_0001);
        set_rd(5'd5, 5'd31, 5'd5);
        expect_val(0, 32'hDEAD_BEEF, "basic_rd1_r5");
        expect_val(1, 32'h0000_0001, "basic_rd2_r31");
        expect_val(2, 32'hDEAD_BEEF, "basic_dbg_r5");
        sample();
        set_rd(5'd31, 5'd5, 5'd31);
        expect_val(0, 32'h0000_0001, "basic_rd1_r31");
        expect_val(1, 32'hDEAD_BEEF, "basic_rd2_r5");
        expect_val(2, 32'h0000_0001, "basic_dbg_r31");
        sample();

        // Zero register ignores writes, before and after the edge.
        set_rd(5'd0, 5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        expect_val(0, 32'h0, "zero_rd1_pre");
        expect_val(1, 32'h0, "zero_rd2_pre");
        sample();
        tick();
        expect_val(0, 32'h0, "zero_rd1_post");
        expect_val(2, 32'h0, "zero_dbg_post");
        sample();
        wr_en = 1'b0;

        // Read during write on r7.
        write(5'd7, 32'h1111_1111);
        rdw_exp = Bypass ? 32'h2222_2222 : 32'h1111_1111;
        set_rd(5'd7, 5'd7, 5'd7);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2222_2222;
        expect_val(0, rdw_exp, "rdw_rd1_pre");
        expect_val(1, rdw_exp, "rdw_rd2_pre");
        expect_val(2, 32'h1111_1111, "rdw_dbg_pre");
        sample();
        tick();
        wr_en = 1'b0;
        expect_val(0, 32'h2222_2222, "rdw_rd1_post");
        expect_val(1, 32'h2222_2222, "rdw_rd2_post");
        expect_val(2, 32'h2222_2222, "rdw_dbg_post");
        sample();

        // wr_en low holds r9 across three edges.
        write(5'd9, 32'h0000_0099);
        set_rd(5'd9, 5'd9, 5'd9);
        wr_addr = 5'd9; wr_data = 32'hA5A5_A5A5;
        expect_val(0, 32'h0000_0099, "wren_low_rd1_pre");
        sample();
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_val(0, 32'h0000_0099, "wren_low_rd1");
            expect_val(2, 32'h0000_0099, "wren_low_dbg");
            sample();
        end

        // Back-to-back writes to r10: each value visible for the cycle after its edge.
        set_rd(5'd10, 5'd10, 5'd10);
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0000_0001;
        tick();
        wr_data = 32'h0000_0002;
        expect_val(2, 32'h0000_0001, "b2b_dbg_first");
        expect_val(0, Bypass ? 32'h0000_0002 : 32'h0000_0001, "b2b_rd1_first");
        sample();
        tick();
        wr_en = 1'b0;
        expect_val(2, 32'h0000_0002, "b2b_dbg_second");
        expect_val(1, 32'h0000_0002, "b2b_rd2_second");
        sample();

        // Async reset mid-cycle.
        write(5'd1, 32'h0000_0101);
        write(5'd2, 32'h0000_0202);
        write(5'd3, 32'h0000_0303);
        set_rd(5'd1, 5'd2, 5'd3);
        expect_val(0, 32'h0000_0101, "fill_rd1_r1");
        expect_val(1, 32'h0000_0202, "fill_rd2_r2");
        expect_val(2, 32'h0000_0303, "fill_dbg_r3");
        sample();
        rst_n = 1'b0;
        expect_val(0, 32'h0, "async_rst_rd1");
        expect_val(1, 32'h0, "async_rst_rd2");
        expect_val(2, 32'h0, "async_rst_dbg");
        sample();
        set_rd(5'd4, 5'd4, 5'd4);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_0444;
        expect_val(0, 32'h0, "rst_no_bypass_rd1");
        sample();
        tick();
        wr_en = 1'b0;
        rst_n = 1'b1;
        expect_val(0, 32'h0, "rst_write_lost_rd1");
        expect_val(2, 32'h0, "rst_write_lost_dbg");
        sample();
        set_rd(5'd1, 5'd2, 5'd3);
        expect_val(0, 32'h0, "rst_cleared_r1");
        expect_val(1, 32'h0, "rst_cleared_r2");
        expect_val(2, 32'h0, "rst_cleared_r3");
        sample();
        write(5'd4, 32'h0000_0444);
        set_rd(5'd4, 5'd0, 5'd4);
        expect_val(2, 32'h0000_0444, "post_rst_write_dbg");
        expect_val(0, 32'h0000_0444, "post_rst_write_rd1");
        sample();

        #10;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
